// File: rtl/subtrator_serial.sv
// Bit-serial subtractor: R = A - B - Bin, one bit per clock, LSB first.
// A start in IDLE or DONE latches the operands. N SHIFT cycles follow. The last
// SHIFT edge enters DONE and loads R, Bout, Z and V together.
// done is a registered pulse one edge after DONE. It is high in the cycle
// after edge k+N+1 when start was accepted at edge k. The results are already
// stable by then and stay unchanged until the next DONE.
module subtrator_serial #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         Bin,
   output logic [N-1:0] R,
   output logic         Bout,
   output logic         Z,
   output logic         V,
   output logic         busy,
   output logic         done
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   a_q, a_d;
   logic [N-1:0]   b_q, b_d;
   logic [N-1:0]   res_q, res_d;
   logic           brw_q, brw_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   // Operand sign bits, kept because the shift registers lose them.
   logic           a_msb_q, a_msb_d;
   logic           b_msb_q, b_msb_d;
   logic [N-1:0]   r_q, r_d;
   logic           bout_q, bout_d;
   logic           z_q, z_d;
   logic           v_q, v_d;
   logic           done_q, done_d;

   // One full-subtractor slice on the current LSBs.
   logic           a0, b0, diff_bit, brw_next;
   logic [N-1:0]   res_shifted;

   assign a0          = a_q[0];
   assign b0          = b_q[0];
   assign diff_bit    = a0 ^ b0 ^ brw_q;
   assign brw_next    = (~a0 & b0) | (~(a0 ^ b0) & brw_q);
   assign res_shifted = {diff_bit, res_q[N-1:1]};

   // Next-state, datapath and result-register logic.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      brw_d   = brw_q;
      cnt_d   = cnt_q;
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      r_d     = r_q;
      bout_d  = bout_q;
      z_d     = z_q;
      v_d     = v_q;
      done_d  = (state_q == DONE);

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               brw_d   = Bin;
               a_msb_d = A[N-1];
               b_msb_d = B[N-1];
               res_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            res_d = res_shifted;
            a_d   = {1'b0, a_q[N-1:1]};
            b_d   = {1'b0, b_q[N-1:1]};
            brw_d = brw_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
               state_d = DONE;
               r_d     = res_shifted;
               bout_d  = brw_next;
               z_d     = ~|res_shifted;
               v_d     = (a_msb_q != b_msb_q) && (res_shifted[N-1] != a_msb_q);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and register update with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         brw_q   <= 1'b0;
         cnt_q   <= '0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         r_q     <= '0;
         bout_q  <= 1'b0;
         z_q     <= 1'b0;
         v_q     <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         brw_q   <= brw_d;
         cnt_q   <= cnt_d;
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         r_q     <= r_d;
         bout_q  <= bout_d;
         z_q     <= z_d;
         v_q     <= v_d;
         done_q  <= done_d;
      end
   end

   assign R    = r_q;
   assign Bout = bout_q;
   assign Z    = z_q;
   assign V    = v_q;
   assign busy = (state_q == SHIFT);
   assign done = done_q;

endmodule

// File: doc/subtrator_serial.md
SUBTRATOR_SERIAL -- requirements
Module: subtrator_serial

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the operand and result width in bits (N >= 2).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset: asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, request to begin a subtraction with the current A, B and Bin.
REQ-005 The block SHALL have port A, input, N, the minuend.
REQ-006 The block SHALL have port B, input, N, the subtrahend.
REQ-007 The block SHALL have port Bin, input, 1, the borrow-in.
REQ-008 The block SHALL have port R, output, N, the registered difference A - B - Bin.
REQ-009 The block SHALL have port Bout, output, 1, the final borrow-out.
REQ-010 The block SHALL have port Z, output, 1, set when R == 0.
REQ-011 The block SHALL have port V, output, 1, the two's-complement signed overflow.
REQ-012 The block SHALL have port busy, output, 1, high while a subtraction is in progress.
REQ-013 The block SHALL have port done, output, 1, a one-cycle pulse marking valid results.

Function
REQ-014 The block SHALL be an FSM with states IDLE, SHIFT and DONE.
REQ-015 In IDLE or DONE, start=1 SHALL, on that edge:
- latch A, B and Bin into internal shift and borrow registers;
- clear the bit counter;
- enter SHIFT.
REQ-016 In SHIFT, each cycle SHALL process one bit, LSB first, as follows:
- d = a0 ^ b0 ^ brw;
- brw' = (~a0 & b0) | (~(a0 ^ b0) & brw);
- shift d into the MSB of the internal result register (right shift);
- shift the A and B registers right.
REQ-017 After exactly N SHIFT cycles the FSM SHALL enter DONE and, on that same edge, load R, Bout, Z and V.
REQ-018 Latency: with start sampled at edge k, done SHALL be high during the cycle after edge k+N+1 (N+1 edges after acceptance).
REQ-019 In DONE, done SHALL be 1 for exactly one cycle; the FSM then returns to IDLE unless start=1, which begins a new operation (back-to-back).
REQ-020 busy SHALL be 1 exactly while in SHIFT.
REQ-021 start SHALL be ignored while busy=1; A, B and Bin changes during SHIFT SHALL NOT affect the result.
REQ-022 R, Bout, Z and V SHALL hold their last values from DONE until the next DONE and SHALL NOT change during SHIFT.
REQ-023 Bout SHALL equal 1 iff A < B + Bin (unsigned).
REQ-024 V SHALL equal (A[N-1] != B[N-1]) && (R[N-1] != A[N-1]), where A and B are the latched operands.
REQ-025 The bit counter SHALL be ceil(log2(N+1)) bits wide and SHALL never wrap within an operation.

Reset
REQ-026 rst_n=0 SHALL, at any time including mid-SHIFT, immediately force:
- state IDLE;
- R=0, Bout=0, Z=0, V=0, busy=0, done=0;
- internal registers and counter cleared.
REQ-027 A subtraction interrupted by reset SHALL be abandoned and SHALL produce no done pulse.
REQ-028 After rst_n deasserts, the first start sampled at a rising edge SHALL be accepted normally.

Verification (N=8)
REQ-029 The bench SHALL cover: A=0x05, B=0x03, Bin=0, start at edge k -> busy high for 8 cycles; done at k+9; R=0x02, Bout=0, Z=0, V=0.
REQ-030 The bench SHALL cover: A=0x03, B=0x05, Bin=0 -> R=0xFE, Bout=1, V=0; A=0x00, B=0x00, Bin=1 -> R=0xFF, Bout=1.
REQ-031 The bench SHALL cover: A=0x80, B=0x01 -> R=0x7F, V=1, Bout=0; A=0x10, B=0x10 -> R=0x00, Z=1, Bout=0.
REQ-032 The bench SHALL cover: start pulsed and A/B changed at 3 cycles into SHIFT -> ignored; result matches the originally latched operands; exactly one done pulse.
REQ-033 The bench SHALL cover: rst_n low 4 cycles into SHIFT -> all outputs 0 immediately; no done pulse; a following start with A=0x09, B=0x04 -> R=0x05.
REQ-034 The bench SHALL cover: start held high through DONE -> a second operation starts with no IDLE cycle between; two done pulses 9 cycles apart.
